// File: rtl/burst_expander.sv
// rtl/burst_expander.sv - expands one length command into a stream of indexed beats (optional BURST_EXPANDER_ABORT_EN)
module burst_expander #(
   parameter int CW = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          src_rdy,
   output logic          src_ack,
   input  logic [CW-1:0] i_len,
`ifdef BURST_EXPANDER_ABORT_EN
   input  logic          i_abort,
`endif
   output logic          dst_rdy,
   input  logic          dst_ack,
   output logic [CW-1:0] o_idx,
   output logic          o_first,
   output logic          o_last,
   output logic          o_busy
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [CW-1:0] len_q;
   logic [CW-1:0] len_d;
   logic [CW-1:0] idx_d;
   logic          terminal;

   // Terminal is a compare against the latched length, so the index never wraps.
`ifdef BURST_EXPANDER_ABORT_EN
   assign terminal = (o_idx == len_q) || i_abort;
`else
   assign terminal = (o_idx == len_q);
`endif

   assign dst_rdy = (state_q == RUN);
   assign o_busy  = dst_rdy;
   assign o_first = dst_rdy && (o_idx == '0);
   assign o_last  = dst_rdy && terminal;

   // Accept and next-state: a new command is taken when idle or on the ack of the last beat.
   always_comb begin
      src_ack = 1'b0;
      state_d = state_q;
      len_d   = len_q;
      idx_d   = o_idx;
      if (src_rdy && (!dst_rdy || (dst_ack && o_last))) begin
         src_ack = 1'b1;
         state_d = RUN;
         len_d   = i_len;
         idx_d   = '0;
      end else if (dst_rdy && dst_ack) begin
         if (o_last) begin
            state_d = IDLE;
            idx_d   = '0;
         end else begin
            idx_d = o_idx + 1'b1;
         end
      end
   end

   // State, latched length and beat index; reset discards any burst in flight.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         o_idx   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         o_idx   <= idx_d;
      end
   end

endmodule
